des128_round_key_gen: RTL and testbench



---
 rtl/des128_pkg.sv | 42 ++++
 rtl/des128_round_key_gen_if.sv | 33 +++
 rtl/des128_key_compress.sv | 17 +
 rtl/des128_round_key_gen.sv | 126 ++++++++++++
 tb/tb_des128_round_key_gen.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/des128_pkg.sv
// -----------------------------------------------------------------------------
// des128_pkg
// Shared constants, the per-round rotation table, the rotate and compression
// helpers, and the FSM state type for the 128-bit expanded DES key schedule.
// -----------------------------------------------------------------------------
package des128_pkg;

   localparam int KEY_W  = 128;
   localparam int RK_W   = 96;
   localparam int ROUNDS = 16;

   // Left-rotation applied to each half when stepping from round i-1 to i.
   // The entries add up to 28, which is what the decrypt pre-rotation uses.
   localparam logic [5:0] SHIFT_TABLE [1:16] = '{
      6'd1, 6'd1, 6'd2, 6'd2, 6'd2, 6'd2, 6'd2, 6'd2,
      6'd1, 6'd2, 6'd2, 6'd2, 6'd2, 6'd2, 6'd2, 6'd1
   };

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   function automatic logic [63:0] rol64(input logic [63:0] x, input logic [5:0] amt);
      return (amt == 6'd0) ? x : ((x << amt) | (x >> (7'd64 - {1'b0, amt})));
   endfunction

   function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] amt);
      return (amt == 6'd0) ? x : ((x >> amt) | (x << (7'd64 - {1'b0, amt})));
   endfunction

   // Keeps the low three bits of every nibble: nibble n lands at out[3n+2:3n].
   function automatic logic [47:0] keep3(input logic [63:0] x);
      logic [47:0] r;
      r = '0;
      for (int n = 0; n < 16; n++) begin
         r[3*n +: 3] = x[4*n +: 3];
      end
      return r;
   endfunction

endpackage

// File: rtl/des128_round_key_gen_if.sv
// -----------------------------------------------------------------------------
// des128_round_key_gen_if
// Load/handshake bundle of the key schedule.
//   load, mode, key_in : start request (sampled only while idle)
//   busy, done         : sequence status
//   rk_valid, rk_ready : round key handshake
//   rk_out, rk_idx     : current round key and its round number minus 1
// master = key consumer / controller side, slave = key generator side.
// -----------------------------------------------------------------------------
interface des128_round_key_gen_if;
   import des128_pkg::*;

   logic             load;
   logic             mode;
   logic [KEY_W-1:0] key_in;
   logic             busy;
   logic             rk_valid;
   logic             rk_ready;
   logic [RK_W-1:0]  rk_out;
   logic [3:0]       rk_idx;
   logic             done;

   modport master (
      output load, mode, key_in, rk_ready,
      input  busy, rk_valid, rk_out, rk_idx, done
   );

   modport slave (
      input  load, mode, key_in, rk_ready,
      output busy, rk_valid, rk_out, rk_idx, done
   );

endinterface

// File: rtl/des128_key_compress.sv
// -----------------------------------------------------------------------------
// des128_key_compress
// Pure combinational compression of the C/D halves into a 96-bit round key.
//   c_half, d_half : 64-bit rotated key halves
//   rk             : {keep3(c_half), keep3(d_half)}
// -----------------------------------------------------------------------------
module des128_key_compress
   import des128_pkg::*;
(
   input  logic [63:0]     c_half,
   input  logic [63:0]     d_half,
   output logic [RK_W-1:0] rk
);

   assign rk = {keep3(c_half), keep3(d_half)};

endmodule

// File: rtl/des128_round_key_gen.sv
// -----------------------------------------------------------------------------
// des128_round_key_gen
// Sequential key schedule: accepts a 128-bit master key and hands out sixteen
// 96-bit round keys one per rk_valid/rk_ready handshake, in encrypt order
// (round 1..16) or decrypt order (round 16..1).
//   CLK : rising-edge clock
//   RST : asynchronous active-high reset
//   bus : des128_round_key_gen_if slave (load/mode/key_in, handshake, status)
// -----------------------------------------------------------------------------
module des128_round_key_gen
   import des128_pkg::*;
(
   input  logic                    CLK,
   input  logic                    RST,
   des128_round_key_gen_if.slave   bus
);

   state_t      state_q, state_d;
   logic [63:0] c_q, c_d;
   logic [63:0] d_q, d_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic        mode_q, mode_d;
   logic        done_q, done_d;

   logic        accept;
   logic [4:0]  tbl_sel;
   logic [5:0]  step;

   // Register bank: everything returns to zero / IDLE on reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
      end
   end

   // Rotation for the next step. Encrypt moves from round idx+1 to idx+2 and
   // uses that round's table entry; decrypt undoes the step into round idx+1.
   always_comb begin
      tbl_sel = mode_q ? ({1'b0, idx_q} + 5'd1) : ({1'b0, idx_q} + 5'd2);
      if (tbl_sel == 5'd0 || tbl_sel > 5'd16) begin
         step = 6'd0;
      end else begin
         step = SHIFT_TABLE[tbl_sel];
      end
   end

   assign accept = (state_q == EMIT) && bus.rk_ready;

   // Next-state logic. Decrypt starts from C16/D16, reached by the total
   // rotation of 28, then walks backwards with right rotations.
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      mode_d  = mode_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.load) begin
               state_d = EMIT;
               mode_d  = bus.mode;
               cnt_d   = 4'd0;
               if (bus.mode) begin
                  c_d   = rol64(bus.key_in[127:64], 6'd28);
                  d_d   = rol64(bus.key_in[63:0], 6'd28);
                  idx_d = 4'd15;
               end else begin
                  c_d   = rol64(bus.key_in[127:64], SHIFT_TABLE[1]);
                  d_d   = rol64(bus.key_in[63:0], SHIFT_TABLE[1]);
                  idx_d = 4'd0;
               end
            end
         end
         EMIT: begin
            if (accept) begin
               if (cnt_q == 4'd15) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
                  if (mode_q) begin
                     c_d   = ror64(c_q, step);
                     d_d   = ror64(d_q, step);
                     idx_d = idx_q - 4'd1;
                  end else begin
                     c_d   = rol64(c_q, step);
                     d_d   = rol64(d_q, step);
                     idx_d = idx_q + 4'd1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   des128_key_compress u_compress (
      .c_half (c_q),
      .d_half (d_q),
      .rk     (bus.rk_out)
   );

   assign bus.busy     = (state_q == EMIT);
   assign bus.rk_valid = (state_q == EMIT);
   assign bus.rk_idx   = idx_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_des128_round_key_gen.sv
// -----------------------------------------------------------------------------
// tb_des128_round_key_gen
// Self-checking bench for des128_round_key_gen with a cumulative-rotation
// reference model and a per-cycle compare process.
// -----------------------------------------------------------------------------
module tb_des128_round_key_gen;

   logic CLK = 1'b0;
   logic RST;

   always #5 CLK = ~CLK;

   des128_round_key_gen_if bus();

   des128_round_key_gen dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   int compared   = 0;
   int mismatched = 0;

   int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   // Reference key for round r (1..16): each half rotated left by the total
   // of the first r table entries, then bit j of the 48-bit half key is taken
   // from bit 4*(j/3) + j%3 of the rotated half.
   function automatic logic [95:0] modelKey(input logic [127:0] key, input int round);
      int amt;
      logic [63:0] c, d, rc, rd;
      logic [95:0] k;
      amt = 0;
      for (int i = 0; i < round; i++) amt += shifts[i];
      c = key[127:64];
      d = key[63:0];
      for (int j = 0; j < 64; j++) begin
         rc[j] = c[(j - amt + 64) % 64];
         rd[j] = d[(j - amt + 64) % 64];
      end
      for (int j = 0; j < 48; j++) begin
         k[48 + j] = rc[4 * (j / 3) + (j % 3)];
         k[j]      = rd[4 * (j / 3) + (j % 3)];
      end
      return k;
   endfunction

   task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs shortly after the rising edge.
   task automatic applyStimulus(input bit ld, input bit md, input logic [127:0] k, input bit rdy);
      @(posedge CLK);
      #1;
      bus.load     = ld;
      bus.mode     = md;
      bus.key_in   = k;
      bus.rk_ready = rdy;
   endtask

   task automatic waitDone(input int budget);
      int n;
      n = 0;
      while (n < budget) begin
         @(posedge CLK);
         #1;
         if (bus.done) break;
         n++;
      end
      if (n >= budget) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL done_timeout: got no done pulse, expected one within %0d cycles", budget);
      end
   endtask

   task automatic runSession(input logic [127:0] k, input bit md);
      applyStimulus(1'b1, md, k, 1'b1);
      applyStimulus(1'b0, md, k, 1'b1);
      waitDone(40);
   endtask

   // Model state, advanced once per cycle by the compare process.
   logic [127:0] mKey;
   bit           mMode;
   bit           mActive;
   bit           mDone;
   int           mPos;
   int           expIdx;
   bit           nextDone;

   // Compare process: on each falling edge check the outputs against the
   // model, then predict what the next rising edge will do.
   always @(negedge CLK) begin
      if (RST) begin
         checkOutput("reset_valid", 96'(bus.rk_valid), 96'h0);
         checkOutput("reset_busy",  96'(bus.busy),     96'h0);
         checkOutput("reset_done",  96'(bus.done),     96'h0);
         checkOutput("reset_idx",   96'(bus.rk_idx),   96'h0);
         checkOutput("reset_out",   bus.rk_out,        96'h0);
         mActive = 1'b0;
         mDone   = 1'b0;
         mPos    = 0;
      end else begin
         checkOutput("rk_valid", 96'(bus.rk_valid), 96'(mActive));
         checkOutput("busy",     96'(bus.busy),     96'(mActive));
         checkOutput("done",     96'(bus.done),     96'(mDone));
         if (mActive) begin
            expIdx = mMode ? (15 - mPos) : mPos;
            checkOutput("rk_idx", 96'(bus.rk_idx), 96'(expIdx));
            checkOutput("rk_out", bus.rk_out, modelKey(mKey, expIdx + 1));
         end
         nextDone = 1'b0;
         if (mActive) begin
            if (bus.rk_ready) begin
               mPos++;
               if (mPos == 16) begin
                  mActive  = 1'b0;
                  nextDone = 1'b1;
               end
            end
         end else if (bus.load) begin
            mActive = 1'b1;
            mKey    = bus.key_in;
            mMode   = bus.mode;
            mPos    = 0;
         end
         mDone = nextDone;
      end
   end

   initial begin
      logic [127:0] k;
      bit           md;
      bit           holdLoad;
      int           n;

      mActive      = 1'b0;
      mDone        = 1'b0;
      mPos         = 0;
      RST          = 1'b1;
      bus.load     = 1'b0;
      bus.mode     = 1'b0;
      bus.key_in   = '0;
      bus.rk_ready = 1'b0;

      // Hand-computed values that pin the reference model.
      checkOutput("model_r1",  modelKey(128'h1, 1),  96'h2);
      checkOutput("model_r2",  modelKey(128'h1, 2),  96'h4);
      checkOutput("model_r3",  modelKey(128'h1, 3),  96'h8);
      checkOutput("model_r16", modelKey(128'h1, 16), 96'h200000);
      checkOutput("model_hi",  modelKey({64'h1, 64'h0}, 1), 96'h2 << 48);

      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      repeat (2) @(posedge CLK);

      $display("[TB] zero key, encrypt");
      runSession(128'h0, 1'b0);

      $display("[TB] unit key, encrypt");
      runSession(128'h1, 1'b0);

      $display("[TB] unit key, decrypt");
      runSession(128'h1, 1'b1);

      $display("[TB] stall on first key");
      applyStimulus(1'b1, 1'b0, 128'h1, 1'b0);
      applyStimulus(1'b0, 1'b0, 128'h1, 1'b0);
      repeat (5) begin
         checkOutput("stall_out",   bus.rk_out,        96'h2);
         checkOutput("stall_valid", 96'(bus.rk_valid), 96'h1);
         @(posedge CLK);
         #1;
      end
      bus.rk_ready = 1'b1;
      @(posedge CLK);
      #1;
      checkOutput("after_stall_out", bus.rk_out, 96'h4);
      waitDone(40);

      $display("[TB] load ignored mid-sequence");
      applyStimulus(1'b1, 1'b0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b1);
      applyStimulus(1'b0, 1'b0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b1);
      applyStimulus(1'b0, 1'b0, 128'h0, 1'b1);
      applyStimulus(1'b1, 1'b1, 128'hdead_beef_0000_1111_2222_3333_4444_5555, 1'b1);
      applyStimulus(1'b1, 1'b1, 128'hdead_beef_0000_1111_2222_3333_4444_5555, 1'b1);
      applyStimulus(1'b0, 1'b0, 128'h0, 1'b1);
      waitDone(40);

      $display("[TB] reset after 7 accepts");
      applyStimulus(1'b1, 1'b0, 128'h5555_aaaa_3333_cccc_0f0f_f0f0_1234_5678, 1'b1);
      applyStimulus(1'b0, 1'b0, 128'h0, 1'b1);
      repeat (7) @(posedge CLK);
      #2 RST = 1'b1;
      #1;
      checkOutput("async_rst_valid", 96'(bus.rk_valid), 96'h0);
      checkOutput("async_rst_busy",  96'(bus.busy),     96'h0);
      @(posedge CLK);
      #1 RST = 1'b0;
      repeat (3) @(posedge CLK);
      runSession(128'hfeed_face_cafe_babe_0bad_f00d_1357_9bdf, 1'b0);

      $display("[TB] randomized sessions");
      for (int s = 0; s < 24; s++) begin
         k        = {$urandom, $urandom, $urandom, $urandom};
         md       = 1'($urandom);
         holdLoad = ($urandom_range(0, 2) == 0);
         applyStimulus(1'b1, md, k, 1'($urandom));
         n = 0;
         while (n < 300) begin
            @(posedge CLK);
            #1;
            if (bus.done) break;
            bus.rk_ready = ($urandom_range(0, 3) != 0);
            bus.load     = holdLoad ? 1'b1 : ($urandom_range(0, 7) == 0);
            bus.mode     = 1'($urandom);
            bus.key_in   = {$urandom, $urandom, $urandom, $urandom};
            n++;
         end
         if (n >= 300) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL random_timeout: got no done pulse, expected one within 300 cycles");
         end
      end

      // Drain any session started by a load held through the last done.
      bus.load     = 1'b0;
      bus.rk_ready = 1'b1;
      repeat (40) @(posedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
